// File: rtl/scr_file_smi.sv
// SCR file front-end on the SMI port: decodes reads and writes onto N_REGS SCR lanes.
// Responses are registered one cycle after accept and are held under backpressure.
module scr_file_smi #(
  parameter int DATA_W    = 64,
  parameter int N_REGS    = 64,
  parameter int ADDR_W    = 6,
  parameter int WRITE_ACK = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     io_smi_req_ready,
  input  logic                     io_smi_req_valid,
  input  logic                     io_smi_req_bits_rw,
  input  logic [ADDR_W-1:0]        io_smi_req_bits_addr,
  input  logic [DATA_W-1:0]        io_smi_req_bits_data,
  input  logic                     io_smi_resp_ready,
  output logic                     io_smi_resp_valid,
  output logic [DATA_W-1:0]        io_smi_resp_bits,
  output logic                     io_smi_resp_err,
  input  logic [N_REGS*DATA_W-1:0] io_scr_rdata,
  output logic                     io_scr_wen,
  output logic [ADDR_W-1:0]        io_scr_waddr,
  output logic [DATA_W-1:0]        io_scr_wdata
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t            state, state_nxt;
  logic              in_range, fire, gen;
  logic [DATA_W-1:0] rd_sel;

  // A fully populated address space cannot go out of range, so no comparator.
  generate
    if (N_REGS >= (1 << ADDR_W)) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = {1'b0, io_smi_req_bits_addr} < (ADDR_W+1)'(N_REGS);
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < N_REGS; i++)
      if (io_smi_req_bits_addr == ADDR_W'(i)) rd_sel = io_scr_rdata[i*DATA_W +: DATA_W];
  end

  assign io_smi_req_ready  = ~reset & ((state == EMPTY) | io_smi_resp_ready);
  assign fire              = io_smi_req_valid & io_smi_req_ready;
  assign gen               = fire & (~io_smi_req_bits_rw | (WRITE_ACK != 0));
  assign io_scr_wen        = fire & io_smi_req_bits_rw & in_range;
  assign io_scr_waddr      = io_smi_req_bits_addr;
  assign io_scr_wdata      = io_smi_req_bits_data;
  assign io_smi_resp_valid = (state == FULL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (gen) state_nxt = FULL;
      FULL:  if (io_smi_resp_ready) state_nxt = gen ? FULL : EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  // Response payload only moves on a load; draining leaves it in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      io_smi_resp_bits <= '0;
      io_smi_resp_err  <= 1'b0;
    end else if (gen) begin
      io_smi_resp_bits <= (io_smi_req_bits_rw | ~in_range) ? '0 : rd_sel;
      io_smi_resp_err  <= ~in_range;
    end
  end

endmodule

// File: tb/tb_scr_file_smi.sv
// Bench for scr_file_smi: three configurations share one stimulus stream and are
// checked every cycle against a transaction-level model, plus directed literal checks.
module tb_scr_file_smi;
  localparam int NK = 3;
  localparam int NR [NK] = '{64, 64, 40};
  localparam int WA [NK] = '{0, 1, 1};

  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_rw = 0, resp_ready = 0;
  logic [5:0]  req_addr = 0;
  logic [63:0] req_data = 0;
  logic [63:0] rd [64];
  logic [64*64-1:0] flat;

  logic        rdy [NK], rv [NK], rerr [NK], wen [NK];
  logic [63:0] rbits [NK], wdata [NK];
  logic [5:0]  waddr [NK];

  int total = 0, bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 64; g++) begin : g_flat
    assign flat[g*64 +: 64] = rd[g];
  end

  scr_file_smi #(.DATA_W(64), .N_REGS(64), .ADDR_W(6), .WRITE_ACK(0)) dut0 (
    .clk(clk), .reset(reset), .io_smi_req_ready(rdy[0]), .io_smi_req_valid(req_valid),
    .io_smi_req_bits_rw(req_rw), .io_smi_req_bits_addr(req_addr), .io_smi_req_bits_data(req_data),
    .io_smi_resp_ready(resp_ready), .io_smi_resp_valid(rv[0]), .io_smi_resp_bits(rbits[0]),
    .io_smi_resp_err(rerr[0]), .io_scr_rdata(flat), .io_scr_wen(wen[0]),
    .io_scr_waddr(waddr[0]), .io_scr_wdata(wdata[0]));

  scr_file_smi #(.DATA_W(64), .N_REGS(64), .ADDR_W(6), .WRITE_ACK(1)) dut1 (
    .clk(clk), .reset(reset), .io_smi_req_ready(rdy[1]), .io_smi_req_valid(req_valid),
    .io_smi_req_bits_rw(req_rw), .io_smi_req_bits_addr(req_addr), .io_smi_req_bits_data(req_data),
    .io_smi_resp_ready(resp_ready), .io_smi_resp_valid(rv[1]), .io_smi_resp_bits(rbits[1]),
    .io_smi_resp_err(rerr[1]), .io_scr_rdata(flat), .io_scr_wen(wen[1]),
    .io_scr_waddr(waddr[1]), .io_scr_wdata(wdata[1]));

  scr_file_smi #(.DATA_W(64), .N_REGS(40), .ADDR_W(6), .WRITE_ACK(1)) dut2 (
    .clk(clk), .reset(reset), .io_smi_req_ready(rdy[2]), .io_smi_req_valid(req_valid),
    .io_smi_req_bits_rw(req_rw), .io_smi_req_bits_addr(req_addr), .io_smi_req_bits_data(req_data),
    .io_smi_resp_ready(resp_ready), .io_smi_resp_valid(rv[2]), .io_smi_resp_bits(rbits[2]),
    .io_smi_resp_err(rerr[2]), .io_scr_rdata(flat[40*64-1:0]), .io_scr_wen(wen[2]),
    .io_scr_waddr(waddr[2]), .io_scr_wdata(wdata[2]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: one-entry response slot per configuration, updated per accepted transaction.
  logic        m_v [NK];
  logic [63:0] m_b [NK];
  logic        m_e [NK];

  function automatic logic m_fire(input int k);
    return req_valid && !reset && (!m_v[k] || resp_ready);
  endfunction

  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < NK; k++) begin
      if (reset) begin
        m_v[k] <= 0; m_b[k] <= 0; m_e[k] <= 0;
      end else if (m_fire(k) && (!req_rw || WA[k] == 1)) begin
        m_v[k] <= 1;
        m_e[k] <= (int'(req_addr) >= NR[k]);
        m_b[k] <= (req_rw || int'(req_addr) >= NR[k]) ? 64'h0 : rd[req_addr];
      end else if (m_v[k] && resp_ready) begin
        m_v[k] <= 0;
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < NK; k++) begin
      chk($sformatf("req_ready[%0d]", k), 64'(rdy[k]), 64'(!reset && (!m_v[k] || resp_ready)));
      chk($sformatf("wen[%0d]", k), 64'(wen[k]),
          64'(m_fire(k) && req_rw && int'(req_addr) < NR[k]));
      chk($sformatf("waddr[%0d]", k), 64'(waddr[k]), 64'(req_addr));
      chk($sformatf("wdata[%0d]", k), wdata[k], req_data);
      chk($sformatf("resp_valid[%0d]", k), 64'(rv[k]), 64'(m_v[k]));
      chk($sformatf("resp_bits[%0d]", k), rbits[k], m_b[k]);
      chk($sformatf("resp_err[%0d]", k), 64'(rerr[k]), 64'(m_e[k]));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic req(input logic rw, input logic [5:0] a, input logic [63:0] d);
    req_valid = 1; req_rw = rw; req_addr = a; req_data = d;
  endtask

  logic [63:0] cap;
  int drops;

  initial begin
    for (int i = 0; i < 64; i++) rd[i] = {$urandom, $urandom};
    #3;
    chk("reset req_ready", 64'(rdy[0]), 64'h0);
    chk("reset resp_valid", 64'(rv[0]), 64'h0);
    chk("reset resp_bits", rbits[0], 64'h0);
    chk("reset resp_err", 64'(rerr[0]), 64'h0);
    tick(); tick();
    reset = 0;
    resp_ready = 1;

    // Read addr 5
    rd[5] = 64'hDEAD_BEEF_0123_4567;
    req(0, 6'd5, 64'h0);
    tick(); req_valid = 0; #1;
    chk("rd5 valid", 64'(rv[0]), 64'h1);
    chk("rd5 bits", rbits[0], 64'hDEAD_BEEF_0123_4567);
    chk("rd5 err", 64'(rerr[0]), 64'h0);
    tick();
    chk("rd5 drained", 64'(rv[0]), 64'h0);

    // Write addr 63
    req(1, 6'd63, 64'h1); #1;
    chk("wr63 wen", 64'(wen[0]), 64'h1);
    chk("wr63 waddr", 64'(waddr[0]), 64'd63);
    chk("wr63 wen n40", 64'(wen[2]), 64'h0);
    tick(); req_valid = 0; #1;
    chk("wr63 wen off", 64'(wen[0]), 64'h0);
    chk("wr63 no resp wa0", 64'(rv[0]), 64'h0);
    chk("wr63 ack valid", 64'(rv[1]), 64'h1);
    chk("wr63 ack bits", rbits[1], 64'h0);
    chk("wr63 ack err", 64'(rerr[1]), 64'h0);
    chk("wr63 n40 err", 64'(rerr[2]), 64'h1);
    tick();

    // N_REGS=40 out-of-range read and write
    req(0, 6'd45, 64'h0);
    tick(); req_valid = 0; #1;
    chk("rd45 n40 valid", 64'(rv[2]), 64'h1);
    chk("rd45 n40 err", 64'(rerr[2]), 64'h1);
    chk("rd45 n40 bits", rbits[2], 64'h0);
    chk("rd45 n64 err", 64'(rerr[0]), 64'h0);
    req(1, 6'd45, 64'h55); #1;
    chk("wr45 n40 wen", 64'(wen[2]), 64'h0);
    chk("wr45 n64 wen", 64'(wen[0]), 64'h1);
    tick(); req_valid = 0; tick();

    // Backpressure on read addr 1
    resp_ready = 0;
    cap = rd[1];
    req(0, 6'd1, 64'h0);
    tick(); req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      rd[1] = rd[1] ^ 64'hFFFF_0000_FFFF_0000;
      #1;
      chk("bp ready low", 64'(rdy[0]), 64'h0);
      chk("bp bits stable", rbits[0], cap);
      tick();
    end
    resp_ready = 1; #1;
    chk("bp release ready", 64'(rdy[0]), 64'h1);
    tick();
    chk("bp single hs", 64'(rv[0]), 64'h0);

    // Streaming reads 0..3
    drops = 0;
    for (int i = 0; i < 4; i++) begin
      req(0, 6'(i), 64'h0); #1;
      if (!rdy[0]) drops++;
      tick();
      chk($sformatf("stream %0d bits", i), rbits[0], rd[i]);
      chk($sformatf("stream %0d valid", i), 64'(rv[0]), 64'h1);
    end
    req_valid = 0;
    chk("stream ready drops", 64'(drops), 64'h0);
    tick();
    chk("stream drained", 64'(rv[0]), 64'h0);

    // Async reset while a response is pending
    resp_ready = 0;
    req(0, 6'd7, 64'h0);
    tick(); req_valid = 0;
    chk("pre-reset valid", 64'(rv[0]), 64'h1);
    #2 reset = 1; #1;
    chk("async reset valid", 64'(rv[0]), 64'h0);
    chk("async reset ready", 64'(rdy[0]), 64'h0);
    req(1, 6'd3, 64'h9); #1;
    chk("reset no wen", 64'(wen[0]), 64'h0);
    tick(); tick();
    req_valid = 0; reset = 0;
    tick();

    // Random traffic, checked by the per-cycle compare
    for (int i = 0; i < 300; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_rw     = $urandom_range(0, 1);
      req_addr   = 6'($urandom_range(0, 63));
      req_data   = {$urandom, $urandom};
      resp_ready = ($urandom_range(0, 3) != 0);
      rd[$urandom_range(0, 63)] = {$urandom, $urandom};
      tick();
    end
    req_valid = 0;
    tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
